// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory request, applies
// stall/redirects and emits NOP bubbles. Optional target alignment check: IF_ALIGN_CHECK_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instru_addr_plus4,
    output logic        fetch_busy,
    output logic        addr_misalign
);

    typedef enum logic [1:0] {StBoot, StFetch, StDrain} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        misalign_q, misalign_d;

    logic        redirect;
    logic        accept;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        target_odd;

    assign redirect   = branch_taken | jump;
    assign raw_target = branch_taken ? branch_target : jump_target;

`ifdef IF_ALIGN_CHECK_EN
    assign target     = {raw_target[31:2], 2'b00};
    assign target_odd = |raw_target[1:0];
`else
    assign target     = raw_target;
    assign target_odd = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            pending_q  <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        accept    = 1'b0;
        case (state_q)
            StBoot: state_d = StFetch;
            StFetch: begin
                if (!stall) begin
                    if (redirect) begin
                        accept = 1'b1;
                        if (imem_ready) begin
                            pc_d = target;
                        end else begin
                            pending_d = target;
                            state_d   = StDrain;
                        end
                    end else if (imem_ready) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            StDrain: begin
                // The read at the old pc finishes and is thrown away; newest redirect wins.
                if (!stall) begin
                    if (redirect) begin
                        accept    = 1'b1;
                        pending_d = target;
                    end
                    if (imem_ready) begin
                        pc_d    = redirect ? target : pending_q;
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
        misalign_d = misalign_q | (accept & target_odd);
    end

    always_comb begin
        imem_req          = (state_q != StBoot);
        imem_addr         = pc_q;
        instru_addr_plus4 = pc_q + 32'd4;
        fetch_busy        = (state_q != StFetch) | ~imem_ready;
        addr_misalign     = misalign_q;
        instruction       = 32'h0000_0000;
        if (state_q == StFetch && imem_ready && !stall && !redirect) begin
            instruction = imem_rdata;
        end
    end

endmodule
